fifo_rd_adapter: RTL
====================

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width of FIFO read data and of the output stream data.
REQ-002 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port empty, input, 1 bit: the upstream FIFO has no readable word.
REQ-005 Port r_en, output, 1 bit: the FIFO read strobe, one word per cycle asserted.
REQ-006 Port data_out, input, DATA_WIDTH bits: FIFO read data, valid exactly one cycle after the r_en cycle.
REQ-007 Port m_valid, output, 1 bit: the output stream word is valid.
REQ-008 Port m_ready, input, 1 bit: the downstream consumer accepts the word.
REQ-009 Port m_data, output, DATA_WIDTH bits: output stream data.
REQ-010 Port xfer_count, output, 16 bits: the count of accepted output words; present only with FIFO_RD_STATS_EN.

Function
REQ-011 The block shall convert the FIFO's 1-cycle-latency read port into a valid/ready stream using a 2-entry output buffer.
REQ-012 r_en shall be combinational, asserted iff !empty && !rst && (occ + inflight - pop) < 2.
- occ: buffered words, 0..2.
- inflight: 1 if r_en was asserted in the previous cycle.
- pop: m_valid && m_ready this cycle.
REQ-013 A word shall be captured from data_out in every cycle where inflight == 1; it is never dropped.
REQ-014 The occupancy FSM shall have states S_EMPTY (occ 0), S_ONE (occ 1) and S_TWO (occ 2), with next occ = occ + capture - pop.
REQ-015 m_valid shall be high iff the state is not S_EMPTY; m_data shall equal the oldest buffered word.
REQ-016 m_data shall be stable while m_valid && !m_ready; a word presented shall not be withdrawn.
REQ-017 Simultaneous capture and pop in S_ONE shall stay in S_ONE, with the new word as head.
REQ-018 Simultaneous capture and pop in S_TWO shall stay in S_TWO, with the second word promoted and the new word appended.
REQ-019 Capture in S_TWO without pop cannot occur given REQ-012; an assertion shall flag it.
REQ-020 Throughput shall be 1 word/cycle steady state with m_ready held high and the FIFO non-empty.
REQ-021 Latency shall be 2 cycles from the first r_en to m_valid (r_en at edge N, capture at edge N+1, m_valid after edge N+1).
REQ-022 Output order shall equal FIFO read order.

Reset
REQ-023 While rst is high, r_en = 0 and m_valid = 0.
REQ-024 At the first clk edge with rst high, occ shall become 0 and inflight 0, and xfer_count shall become 0 when present.
REQ-025 A read in flight when rst asserts shall be discarded; no word shall be emitted from it after reset.
REQ-026 m_data need not be reset and is don't-care while m_valid = 0.

Configuration
REQ-027 With macro FIFO_RD_STATS_EN defined, xfer_count shall exist and increment by 1 on each pop, wrapping from 16'hFFFF to 0.
REQ-028 Without FIFO_RD_STATS_EN, the xfer_count port and its register shall be absent; all other behaviour is identical.

Structure
REQ-029 Shared package fifo_pkg shall hold the DATA_WIDTH default, the occupancy state enum (S_EMPTY, S_ONE, S_TWO) and the XFER_CNT_W = 16 constant.
REQ-030 The 2-entry buffer shall be sub-module fifo_rd_skid (2 registers plus head select), instantiated once.
REQ-031 The top level shall hold r_en generation, inflight tracking, the FSM and the optional counter.

Verification
REQ-032 Reset mid-stream: FIFO holds 8'hA1..8'hA4, m_ready=1, rst pulsed the cycle after the second r_en -> no word follows reset until new r_en; m_valid=0, occ=0.
REQ-033 Streaming: FIFO preloaded with 8'h01..8'h08, m_ready=1 -> m_data 01..08 on consecutive cycles, first m_valid 2 cycles after the first r_en.
REQ-034 Backpressure: m_ready=0 with FIFO holding 8'h10..8'h13 -> exactly 2 r_en pulses, m_valid=1 with m_data=8'h10 held stable; after m_ready=1, output is 10,11,12,13 in order.
REQ-035 Empty boundary: empty toggles 1/0 each cycle with m_ready=1 -> r_en never asserts while empty=1, and no duplicated or lost words.
REQ-036 Random m_ready (50%) with a 256-word stream -> scoreboard order match and no r_en while occ+inflight-pop >= 2.
REQ-037 With FIFO_RD_STATS_EN, 65537 accepted words -> xfer_count = 1 (wrap).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read adapter: default data width, output-buffer
// occupancy states and the transfer-counter width.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned XFER_CNT_W     = 16;

  // The encoding of each state is also its occupancy (0, 1 or 2 buffered words).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_e;

  // Number of buffered words held in a given state.
  function automatic logic [1:0] occ_of(occ_state_e s);
    logic [1:0] occ;
    case (s)
      S_ONE:   occ = 2'd1;
      S_TWO:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer for the FIFO read adapter. Words are written in arrival order
// and read from the head; the occupancy FSM in the parent guarantees no overflow or
// underflow, so the buffer only tracks a write and a read slot.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;

  // Slot pointers; each toggles on its own strobe. With both slots full a write and a
  // read hit the same slot, which retires the head and appends the new word at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (wr_en_i) wr_ptr_q <= ~wr_ptr_q;
      if (rd_en_i) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Data storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts a FIFO read port with one cycle of read latency into a valid/ready stream.
// Reads are issued only when the word is guaranteed a slot in the 2-entry output
// buffer, so a word returned by the FIFO is always captured.
// Optional feature: define FIFO_RD_STATS_EN to add the xfer_count port, a wrapping
// count of accepted output words.
module fifo_rd_adapter
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_count
`endif
);

  occ_state_e state_q, state_d;
  logic       inflight_q;
  logic       capture;
  logic       pop;
  logic [2:0] load;

  assign capture = inflight_q;
  assign m_valid = (state_q != S_EMPTY) && !rst;
  assign pop     = m_valid && m_ready;

  // Words owned by the adapter (buffered plus in flight); a read is allowed only when
  // that count, less the word leaving this cycle, leaves room in the buffer.
  assign load = {1'b0, occ_of(state_q)} + {2'b00, inflight_q};
  assign r_en = !empty && !rst && (load < (3'd2 + {2'b00, pop}));

  // Occupancy next state: occ + capture - pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (capture) state_d = S_ONE;
      end
      S_ONE: begin
        if (capture && !pop)      state_d = S_TWO;
        else if (!capture && pop) state_d = S_EMPTY;
      end
      S_TWO: begin
        if (!capture && pop) state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Occupancy and in-flight tracking; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= r_en;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (capture),
    .wr_data_i (data_out),
    .rd_en_i   (pop),
    .rd_data_o (m_data)
  );

`ifdef FIFO_RD_STATS_EN
  logic [XFER_CNT_W-1:0] xfer_q;

  // Accepted-word counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst)      xfer_q <= '0;
    else if (pop) xfer_q <= xfer_q + XFER_CNT_W'(1);
  end

  assign xfer_count = xfer_q;
`endif

  // A capture into a full buffer without a pop would overwrite the oldest word.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(state_q == S_TWO && capture && !pop));

endmodule
